// File: rtl/ex_stage_pkg.sv
// ex_pkg: shared encodings for the MIPS execute stage.
//   - alu_op encodings driven by the decoder
//   - funct codes decoded when alu_op selects R-type
//   - mul_state_t: iterative multiplier FSM states
//   - ex_mem_t: contents of the EX/MEM pipeline register
package ex_pkg;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    typedef struct packed {
        logic [1:0]  control_wb;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] branch_target;
        logic        alu_zero;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
    } ex_mem_t;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operands and controls into the execute stage, EX/MEM
// register outputs, the flush request from the memory stage and the stall
// back to the front end.
//   master: the surrounding pipeline (drives ID/EX + flush, sees EX/MEM + stall)
//   slave : ex_stage
interface ex_stage_if;
    logic [1:0]  control_wb;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        reg_dst;
    logic [31:0] pc_plus4;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] sign_ext_imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        flush;

    logic [1:0]  control_wb_out;
    logic        branch_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [31:0] branch_target;
    logic        alu_zero;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic        stall;

    modport master (
        output control_wb, branch, mem_read, mem_write, alu_src, alu_op, reg_dst,
               pc_plus4, read_data1, read_data2, sign_ext_imm, rt, rd, flush,
        input  control_wb_out, branch_out, mem_read_out, mem_write_out,
               branch_target, alu_zero, alu_result, write_data, write_reg, stall
    );

    modport slave (
        input  control_wb, branch, mem_read, mem_write, alu_src, alu_op, reg_dst,
               pc_plus4, read_data1, read_data2, sign_ext_imm, rt, rd, flush,
        output control_wb_out, branch_out, mem_read_out, mem_write_out,
               branch_target, alu_zero, alu_result, write_data, write_reg, stall
    );
endinterface

// File: rtl/ex_stage_iter_multiplier.sv
// iter_multiplier: 32-cycle shift-add multiplier, low 32 bits of a*b.
//   clk_1, rst_1 : clock, async active-low reset
//   start        : mul present in EX (sampled only in IDLE)
//   abort        : squash from the memory stage; returns to IDLE from any state
//   a, b         : multiplicand / multiplier
//   busy         : high for the 32 iteration cycles
//   done         : high for the single cycle the product is valid
//   product      : accumulator
module iter_multiplier
    import ex_pkg::*;
(
    input  logic        clk_1,
    input  logic        rst_1,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    mul_state_t  state;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [4:0]  count;

    assign product = acc;

    always_ff @(posedge clk_1 or negedge rst_1) begin
        if (!rst_1) begin
            state  <= MUL_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (abort) begin
            state <= MUL_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    // Only the low 32 product bits are kept, so bits shifted
                    // out of the multiplicand can be dropped.
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                    if (count == 5'd31) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    done  <= 1'b0;
                    state <= MUL_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= MUL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. ALU, operand/destination muxes, branch
// target adder and the EX/MEM pipeline register. MULT runs on the
// iterative multiplier and stalls the front end while it works.
//   clk_1 : pipeline clock, rising edge
//   rst_1 : asynchronous active-low reset
//   pipe  : ex_stage_if.slave (ID/EX in, EX/MEM out, flush in, stall out)
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk_1,
    input  logic        rst_1,
    ex_stage_if.slave   pipe
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [5:0]  funct;
    logic        mul_detect;
    logic        mul_busy;
    logic        mul_done;
    logic        mul_idle;
    logic [31:0] mul_product;
    logic [31:0] alu_out;
    ex_mem_t     ex_mem_d;
    ex_mem_t     ex_mem_q;

    assign op_a       = pipe.read_data1;
    assign op_b       = pipe.alu_src ? pipe.sign_ext_imm : pipe.read_data2;
    assign funct      = pipe.sign_ext_imm[5:0];
    assign mul_detect = (pipe.alu_op == ALU_FUNCT) && (funct == FUNCT_MULT);
    assign mul_idle   = !mul_busy && !mul_done;

    iter_multiplier u_mul (
        .clk_1   (clk_1),
        .rst_1   (rst_1),
        .start   (mul_detect),
        .abort   (pipe.flush),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // A flush in the detect cycle keeps the multiplier idle, so no stall then.
    // The rst_1 gate keeps stall low while a held mul sits in EX during reset.
    assign pipe.stall = rst_1 && ((mul_idle && mul_detect && !pipe.flush) || mul_busy);

    always_comb begin
        alu_out = '0;
        case (pipe.alu_op)
            ALU_ADD: alu_out = op_a + op_b;
            ALU_SUB: alu_out = op_a - op_b;
            ALU_FUNCT: begin
                case (funct)
                    FUNCT_ADD:  alu_out = op_a + op_b;
                    FUNCT_SUB:  alu_out = op_a - op_b;
                    FUNCT_AND:  alu_out = op_a & op_b;
                    FUNCT_OR:   alu_out = op_a | op_b;
                    FUNCT_SLT:  alu_out = {31'b0, $signed(op_a) < $signed(op_b)};
                    // Only reaches EX/MEM in the DONE cycle; stalls bubble it otherwise.
                    FUNCT_MULT: alu_out = mul_product;
                    default:    alu_out = '0;
                endcase
            end
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        ex_mem_d               = '0;
        ex_mem_d.control_wb    = pipe.control_wb;
        ex_mem_d.branch        = pipe.branch;
        ex_mem_d.mem_read      = pipe.mem_read;
        ex_mem_d.mem_write     = pipe.mem_write;
        ex_mem_d.branch_target = pipe.pc_plus4 + (pipe.sign_ext_imm << 2);
        ex_mem_d.alu_zero      = (alu_out == 32'd0);
        ex_mem_d.alu_result    = alu_out;
        ex_mem_d.write_data    = pipe.read_data2;
        ex_mem_d.write_reg     = pipe.reg_dst ? pipe.rd : pipe.rt;
    end

    // Stall and flush both insert an all-zero bubble.
    always_ff @(posedge clk_1 or negedge rst_1) begin
        if (!rst_1)
            ex_mem_q <= '0;
        else if (pipe.flush || pipe.stall)
            ex_mem_q <= '0;
        else
            ex_mem_q <= ex_mem_d;
    end

    assign pipe.control_wb_out = ex_mem_q.control_wb;
    assign pipe.branch_out     = ex_mem_q.branch;
    assign pipe.mem_read_out   = ex_mem_q.mem_read;
    assign pipe.mem_write_out  = ex_mem_q.mem_write;
    assign pipe.branch_target  = ex_mem_q.branch_target;
    assign pipe.alu_zero       = ex_mem_q.alu_zero;
    assign pipe.alu_result     = ex_mem_q.alu_result;
    assign pipe.write_data     = ex_mem_q.write_data;
    assign pipe.write_reg      = ex_mem_q.write_reg;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed + randomized bench for ex_stage. Expected values come
// from a plain-arithmetic model of the instruction semantics.
module tb_ex_stage;

    logic clk_1;
    logic rst_1;
    int   vectors;
    int   miscompares;

    ex_stage_if bus ();

    ex_stage dut (
        .clk_1 (clk_1),
        .rst_1 (rst_1),
        .pipe  (bus)
    );

    initial clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b10: begin
                case (f)
                    6'h20: return a + b;
                    6'h22: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h18: return a * b;
                    default: return 32'd0;
                endcase
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [1:0] op, input logic src, input logic rdst,
                         input logic [1:0] wb, input logic br, input logic mr, input logic mw,
                         input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd);
        bus.alu_op       = op;
        bus.alu_src      = src;
        bus.reg_dst      = rdst;
        bus.control_wb   = wb;
        bus.branch       = br;
        bus.mem_read     = mr;
        bus.mem_write    = mw;
        bus.pc_plus4     = pc;
        bus.read_data1   = a;
        bus.read_data2   = b;
        bus.sign_ext_imm = imm;
        bus.rt           = rt;
        bus.rd           = rd;
    endtask

    task automatic check_zero_regs(input string tag);
        check({tag, "_res"}, bus.alu_result, 32'd0);
        check({tag, "_ctl"}, {27'd0, bus.control_wb_out, bus.branch_out, bus.mem_read_out,
                              bus.mem_write_out}, 32'd0);
        check({tag, "_tgt"}, bus.branch_target, 32'd0);
        check({tag, "_wd"},  {bus.write_data[31:0]}, 32'd0);
        check({tag, "_wr"},  {27'd0, bus.write_reg, bus.alu_zero} == 33'd0 ? 32'd0 : 32'd1, 32'd0);
    endtask

    // One non-mul instruction: drive, check no stall, clock once, compare all fields.
    task automatic run_single(input string tag, input logic [1:0] op, input logic src,
                              input logic rdst, input logic [1:0] wb, input logic br,
                              input logic mr, input logic mw, input logic [31:0] pc,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd);
        logic [31:0] exp_res;
        drive(op, src, rdst, wb, br, mr, mw, pc, a, b, imm, rt, rd);
        exp_res = model(op, imm[5:0], a, src ? imm : b);
        #1;
        check({tag, "_nostall"}, {31'd0, bus.stall}, 32'd0);
        tick();
        check({tag, "_res"},  bus.alu_result, exp_res);
        check({tag, "_zero"}, {31'd0, bus.alu_zero}, {31'd0, exp_res == 32'd0});
        check({tag, "_tgt"},  bus.branch_target, pc + imm * 4);
        check({tag, "_wd"},   bus.write_data, b);
        check({tag, "_wr"},   {27'd0, bus.write_reg}, {27'd0, rdst ? rd : rt});
        check({tag, "_ctl"},  {27'd0, bus.control_wb_out, bus.branch_out, bus.mem_read_out,
                               bus.mem_write_out}, {27'd0, wb, br, mr, mw});
    endtask

    // A mul: 33 stall cycles of zero bubbles, then the product with real controls.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        drive(2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h1000, a, b, 32'h18, 5'd3, 5'd9);
        #1;
        check({tag, "_detect"}, {31'd0, bus.stall}, 32'd1);
        cyc = 0;
        while (bus.stall === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
            check({tag, "_bubble_res"}, bus.alu_result, 32'd0);
            check({tag, "_bubble_wb"}, {30'd0, bus.control_wb_out}, 32'd0);
        end
        check({tag, "_stall_cycles"}, cyc, 32'd33);
        tick();
        check({tag, "_res"},  bus.alu_result, a * b);
        check({tag, "_zero"}, {31'd0, bus.alu_zero}, {31'd0, (a * b) == 32'd0});
        check({tag, "_wr"},   {27'd0, bus.write_reg}, 32'd9);
        check({tag, "_wb"},   {30'd0, bus.control_wb_out}, 32'd2);
    endtask

    initial begin
        logic [5:0]  ftab [7];
        logic [1:0]  op;
        logic [31:0] imm;
        vectors     = 0;
        miscompares = 0;
        ftab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F, 6'h00};
        bus.flush = 1'b0;
        rst_1 = 1'b0;

        // Reset with a mul waiting in EX: outputs zero, stall forced low.
        drive(2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 32'h40, 32'd6, 32'd7, 32'h18, 5'd1, 5'd2);
        tick();
        check_zero_regs("rst");
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        rst_1 = 1'b1;

        run_single("add57", 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h4, 32'd5, 32'd7, 32'h20, 5'd1, 5'd2);
        check("add57_lit", bus.alu_result, 32'd12);
        run_single("sub33", 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h8, 32'd3, 32'd3, 32'h22, 5'd1, 5'd4);
        check("sub33_zero_lit", {31'd0, bus.alu_zero}, 32'd1);
        run_single("slt", 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h8, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd1, 5'd5);
        check("slt_lit", bus.alu_result, 32'd1);
        run_single("f3f", 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h8, 32'd9, 32'd4, 32'h3F, 5'd1, 5'd6);
        check("f3f_lit", bus.alu_result, 32'd0);
        run_single("lw", 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 32'h40, 32'h100, 32'h55, 32'hFFFF_FFFC, 5'd7, 5'd8);
        check("lw_lit", bus.alu_result, 32'hFC);
        check("lw_rt", {27'd0, bus.write_reg}, 32'd7);
        run_single("beq", 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h40, 32'd2, 32'd2, 32'd3, 5'd0, 5'd0);
        check("beq_tgt_lit", bus.branch_target, 32'h4C);
        run_single("wrap", 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h7FFF_FFFF, 32'd0, 32'd1, 5'd3, 5'd0);
        check("wrap_lit", bus.alu_result, 32'h8000_0000);
        run_single("rsvd", 2'b11, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'd1, 32'd2, 32'h20, 5'd3, 5'd4);

        run_mul("mul_m1x3", 32'hFFFF_FFFF, 32'd3);
        check("mul_lit", bus.alu_result, 32'hFFFF_FFFD);

        // Flush at BUSY cycle 10.
        drive(2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h1000, 32'd123, 32'd456, 32'h18, 5'd3, 5'd9);
        for (int i = 0; i < 10; i++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_zero_regs("flush");
        drive(2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h20, 32'd5, 32'd7, 32'd0, 5'd11, 5'd0);
        #1;
        check("flush_stall_drop", {31'd0, bus.stall}, 32'd0);
        run_single("post_flush", 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h20, 32'd5, 32'd7, 32'd0, 5'd11, 5'd0);
        run_mul("mul_after_flush", 32'd123, 32'd456);

        // Flush coinciding with a mul detect: no stall, bubble.
        drive(2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h1000, 32'd10, 32'd11, 32'h18, 5'd3, 5'd9);
        bus.flush = 1'b1;
        #1;
        check("flush_detect_nostall", {31'd0, bus.stall}, 32'd0);
        tick();
        bus.flush = 1'b0;
        check_zero_regs("flush_detect");
        run_mul("mul_after_fd", 32'd10, 32'd11);

        // Reset mid-operation: add result held, then async reset with mul waiting.
        run_single("pre_rst", 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 32'h80, 32'h11, 32'h22, 32'd5, 5'd4, 5'd0);
        drive(2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h1000, 32'd77, 32'd3, 32'h18, 5'd3, 5'd9);
        #1;
        check("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
        rst_1 = 1'b0;
        #1;
        check("async_rst_stall", {31'd0, bus.stall}, 32'd0);
        check_zero_regs("async_rst");
        tick();
        rst_1 = 1'b1;
        run_mul("mul_redetect", 32'd77, 32'd3);

        // Reset inside BUSY aborts the mul; next add completes normally.
        drive(2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h1000, 32'd8, 32'd9, 32'h18, 5'd3, 5'd9);
        for (int i = 0; i < 6; i++) tick();
        rst_1 = 1'b0;
        #1;
        check("busy_rst_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        rst_1 = 1'b1;
        run_single("post_rst_add", 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'h4, 32'd5, 32'd7, 32'd0, 5'd2, 5'd0);
        check("post_rst_lit", bus.alu_result, 32'd12);

        // Random single-cycle instructions.
        for (int n = 0; n < 40; n++) begin
            op  = 2'($urandom_range(0, 3));
            imm = $urandom;
            if (op == 2'b10) imm[5:0] = ftab[$urandom_range(0, 6)];
            run_single("rnd", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom, $urandom, $urandom, imm,
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Random multiplies.
        for (int n = 0; n < 4; n++) run_mul("rnd_mul", $urandom, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, directly upstream of the memory stage. It computes the ALU result, zero flag, branch target and destination register, and registers them with the WB/M control bits into the EX/MEM pipeline register feeding the memory stage. It also executes `MULT` through an iterative 32-cycle shift-add multiplier, stalling IF/ID/EX while busy. It squashes its output when the memory stage resolves a taken branch.

## Interface
Parameters:
- none; widths fixed at 32-bit data, 5-bit register index.

Ports:
- `clk_1`  in  1  pipeline clock, rising edge.
- `rst_1`  in  1  asynchronous, active-low reset.
- `control_wb`  in  2  WB controls: [1] RegWrite, [0] MemtoReg; passed through.
- `branch, mem_read, mem_write`  in  1 each  M controls; passed through.
- `alu_src`  in  1  ALU B operand: 1 = immediate, 0 = `read_data2`.
- `alu_op`  in  2  00 add, 01 sub, 10 decode `funct`, 11 reserved (result 0).
- `reg_dst`  in  1  destination select: 1 = `rd`, 0 = `rt`.
- `pc_plus4, read_data1, read_data2, sign_ext_imm`  in  32 each  ID/EX operands.
- `rt, rd`  in  5 each  register fields.
- `flush`  in  1  `pcSrc` from the memory stage; a taken branch squashes this stage.
- `control_wb_out`  out  2  registered WB controls.
- `branch_out, mem_read_out, mem_write_out`  out  1 each  registered M controls.
- `branch_target`  out  32  registered `pc_plus4 + (sign_ext_imm << 2)`.
- `alu_zero`  out  1  registered `alu_result == 0`.
- `alu_result`  out  32  registered ALU or multiply result.
- `write_data`  out  32  registered `read_data2`.
- `write_reg`  out  5  registered destination.
- `stall`  out  1  combinational; holds the PC, IF/ID and ID/EX.

## Operation
- B operand = `alu_src ? sign_ext_imm : read_data2`.
- Add and sub wrap modulo 2^32.
- With `alu_op`=10, `funct` = `sign_ext_imm[5:0]`:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
  - 0x2A slt: signed compare, result 1 or 0.
  - 0x18 mul: low 32 bits of the unsigned product, written to `rd`.
  - Any other `funct` gives result 0.
- `alu_zero` is computed on the selected result, including the mul result.
- Multiplier FSM:
  - IDLE: a mul is detected (`alu_op`=10, `funct`=0x18). Load multiplicand = A, multiplier = B, acc = 0, count = 0. Go to BUSY.
  - BUSY: each cycle, if multiplier[0] then acc += multiplicand. Shift multiplicand left and multiplier right; count++. Exit to DONE after the 32nd iteration (count was 31).
  - DONE: acc drives `alu_result`; the EX/MEM register captures the mul with its real controls. Return to IDLE.
- `stall` = (IDLE and mul detected) or BUSY. It is low in DONE and forced low while `rst_1` is low.
- Bubble: while `stall`=1, EX/MEM loads all-zero (controls and data).
- `flush`=1: EX/MEM loads all-zero and the FSM returns to IDLE from any state. `flush` overrides DONE and a new mul detect.
- Non-mul instructions complete in one cycle with no stall.

## Timing
- Reset (`rst_1` low, asynchronous): every registered output is 0, FSM is IDLE, acc/count are 0.
- Single-cycle ops: operands at edge N appear on the outputs after edge N+1; latency 1.
- Mul: detect at edge N; `stall` is high for 33 cycles; result is registered at the 34th edge; the next instruction enters EX in the cycle after DONE.
- Reset asserted mid-multiply aborts immediately. The first cycle after release is IDLE and re-detects the held mul.
- `flush` and a mul detect in the same cycle: flush wins; no stall that cycle.
- `branch_target` wraps modulo 2^32.

## Structure
- Package `ex_pkg` holds:
  - `alu_op` encodings;
  - `funct` constants (ADD, SUB, AND, OR, SLT, MULT);
  - the `mul_state_t` enum (IDLE, BUSY, DONE).
- Sub-module `iter_multiplier` contains the FSM, acc/count datapath, `busy` and `done` flags, and an abort input tied to `flush`.
- The ALU, muxes and EX/MEM register stay in `ex_stage`.

## Test plan
- Reset: `rst_1` low mid-operation → all outputs 0 and `stall`=0 asynchronously. After release, the next add of 5 and 7 → `alu_result`=12 after one edge.
- R-type: sub 3−3 → `alu_result`=0, `alu_zero`=1. slt of −1 vs 1 → 1. `funct` 0x3F → 0.
- lw: `alu_op`=00, imm=−4, A=0x100 → `alu_result`=0xFC, `write_reg`=`rt`. `pc_plus4`=0x40, imm=3 → `branch_target`=0x4C.
- Mul: 0xFFFF_FFFF × 3 → `stall` high for exactly 33 cycles with zero-control bubbles, then `alu_result`=0xFFFF_FFFD, `write_reg`=`rd`, RegWrite=1.
- Flush: assert `flush` at BUSY cycle 10 → EX/MEM all-zero, `stall` drops next cycle, FSM returns to IDLE. A following add completes normally.
- Wrap: add 0x7FFF_FFFF + 1 → 0x8000_0000, no exception.
